inv_sub_bytes_stage: RTL and testbench

//  Byte-serial AES decryption stage: applies InvShiftRows then InvSubBytes to a 128-bit state.

---
 rtl/inv_sub_bytes_stage.sv | 152 +++++++++++++++
 tb/tb_inv_sub_bytes_stage.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_stage.sv
// Byte-serial AES InvShiftRows + InvSubBytes stage.
// BYTES_PER_CYCLE inverse S-boxes are time-shared over the 16 state bytes.

module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 sits in the top byte of the table.
  assign out_byte = TBL[{~in_byte, 3'b111} -: 8];

endmodule

module inv_sub_bytes_stage #(
  parameter int BYTES_PER_CYCLE = 1,
  parameter bit SHIFT_EN        = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int BPC = BYTES_PER_CYCLE;
  localparam int N   = 16 / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 ||
        BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  cap_q, cap_d;
  logic [127:0]  res_q, res_d;

  logic [3:0] dst_idx [BPC];
  logic [3:0] src_idx [BPC];
  logic [7:0] sb_in   [BPC];
  logic [7:0] sb_out  [BPC];

  logic accept;

  assign in_ready  = rst_n && (state_q == IDLE) && !abort;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;

  // Byte k = r + 4c: low two index bits are the row, high two the column.
  always_comb begin
    for (int j = 0; j < BPC; j++) begin
      dst_idx[j] = 4'(int'(cnt_q) * BPC + j);
      if (SHIFT_EN)
        src_idx[j] = {dst_idx[j][3:2] - dst_idx[j][1:0],
                      dst_idx[j][1:0]};
      else
        src_idx[j] = dst_idx[j];
      sb_in[j] = cap_q[{~src_idx[j], 3'b111} -: 8];
    end
  end

  for (genvar g = 0; g < BPC; g++) begin : g_sbox
    inv_sbox u_sbox (
      .in_byte  (sb_in[g]),
      .out_byte (sb_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    res_d   = res_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cap_d   = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          for (int j = 0; j < BPC; j++)
            res_d[{~dst_idx[j], 3'b111} -: 8] = sb_out[j];
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_stage.sv
// Scoreboard bench for inv_sub_bytes_stage.
// Expected states come from an S-box rebuilt from GF(2^8) arithmetic.

module tb_inv_sub_bytes_stage;

  localparam int ND = 4;
  localparam int BPC_T [ND] = '{1, 4, 16, 1};
  localparam bit SH_T  [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [127:0] PAT =
    128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic         abort     [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [127:0] in_data   [ND];
  logic [127:0] out_data  [ND];

  int tests = 0;
  int fails = 0;

  logic [7:0]   inv_sb [256];
  logic [127:0] sb_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    inv_sub_bytes_stage #(
      .BYTES_PER_CYCLE (BPC_T[g]),
      .SHIFT_EN        (SH_T[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .abort     (abort[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_table();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = '0;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) begin
            iv = 8'(y);
            break;
          end
        end
      end
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3)
        ^ rotl(iv, 4) ^ 8'h63;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] din,
                                         input bit sh);
    logic [127:0] r;
    int src, rr, cc;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      rr = i % 4;
      cc = i / 4;
      src = sh ? rr + 4 * ((cc - rr + 4) % 4) : i;
      r[127-8*i -: 8] = inv_sb[din[127-8*src -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] pop_exp();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input int d, input logic [127:0] data,
                      output bit ok);
    ok = 1'b0;
    in_data[d]  = data;
    in_valid[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (in_ready[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) sb_q.push_back(model(data, SH_T[d]));
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat,
                          output logic [127:0] data, output bit to);
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    to   = (out_valid[d] !== 1'b1);
    data = out_data[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      tests++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 ||
          out_data[d] !== '0) begin
        fails++;
        $display("FAIL reset[%0d]: got rdy=%b vld=%b data=%h want 0 0 0",
                 d, in_ready[d], out_valid[d], out_data[d]);
      end
    end
  endtask

  task automatic test_basic();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    send(0, {16{8'h63}}, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_accept: got no accept want accept");
    end
    wait_out(0, lat, got, to);
    exp = pop_exp();
    tests++;
    if (to || lat !== 17) begin
      fails++;
      $display("FAIL basic_latency: got %0d (timeout=%0d) want 17",
               lat, to);
    end
    tests++;
    if (got !== exp || got !== '0) begin
      fails++;
      $display("FAIL basic_data: got %h want %h", got, exp);
    end
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_one_cycle: got vld=%b want 0", out_valid[0]);
    end
  endtask

  task automatic test_shift();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    for (int d = 0; d < 3; d++) begin
      send(d, PAT, ok);
      wait_out(d, lat, got, to);
      exp = pop_exp();
      tests++;
      if (!ok || to || lat !== 16 / BPC_T[d] + 1) begin
        fails++;
        $display("FAIL shift_lat[bpc=%0d]: got %0d want %0d",
                 BPC_T[d], lat, 16 / BPC_T[d] + 1);
      end
      tests++;
      if (got !== exp || got[127 -: 32] !== 32'h52f3a338) begin
        fails++;
        $display("FAIL shift_data[bpc=%0d]: got %h want %h",
                 BPC_T[d], got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_noshift();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    send(3, PAT, ok);
    wait_out(3, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || got !== exp || got[127 -: 32] !== 32'h52096ad5) begin
      fails++;
      $display("FAIL noshift_data: got %h want %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    out_ready[0] = 1'b0;
    send(0, rnd128(), ok);
    wait_out(0, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || got !== exp) begin
      fails++;
      $display("FAIL bp_data: got %h want %h", got, exp);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== exp ||
          in_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%h want 1 0 %h",
                 i, out_valid[0], in_ready[0], out_data[0], exp);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0 1",
               out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_abort();
    bit ok, to, seen;
    int lat;
    logic [127:0] got, exp;
    send(0, rnd128(), ok);
    void'(pop_exp());
    repeat (5) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    #1;
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: got rdy=%b vld=%b want 1 0",
               in_ready[0], out_valid[0]);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_no_out: got vld=1 want 0");
    end
    in_data[0]  = rnd128();
    in_valid[0] = 1'b1;
    abort[0]    = 1'b1;
    #1;
    tests++;
    if (in_ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle_rdy: got %b want 0", in_ready[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    abort[0]    = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_idle_capture: got vld=1 want 0");
    end
    send(0, '0, ok);
    wait_out(0, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || lat !== 17 || got !== exp ||
        got !== {16{8'h52}}) begin
      fails++;
      $display("FAIL abort_next: got %h lat %0d want %h lat 17",
               got, lat, exp);
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
    send(0, rnd128(), ok);
    wait_out(0, lat, got, to);
    exp = pop_exp();
    abort[0]     = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    #1;
    tests++;
    if (to || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        out_data[0] !== exp) begin
      fails++;
      $display("FAIL abort_done: got vld=%b rdy=%b data=%h want 0 1 %h",
               out_valid[0], in_ready[0], out_data[0], exp);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    send(0, rnd128(), ok);
    void'(pop_exp());
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== '0 ||
        in_ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got vld=%b rdy=%b data=%h want 0 0 0",
               out_valid[0], in_ready[0], out_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, PAT, ok);
    wait_out(0, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || lat !== 17 || got !== exp) begin
      fails++;
      $display("FAIL after_reset: got %h lat %0d want %h lat 17",
               got, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    send(1, rnd128(), ok);
    wait_out(1, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || got !== exp) begin
      fails++;
      $display("FAIL b2b_first: got %h want %h", got, exp);
    end
    @(negedge clk);
    send(1, rnd128(), ok);
    wait_out(1, lat, got, to);
    exp = pop_exp();
    tests++;
    if (!ok || to || lat + 1 !== 6 || got !== exp) begin
      fails++;
      $display("FAIL b2b_period: got %0d data %h want 6 data %h",
               lat + 1, got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok, to;
    int lat;
    logic [127:0] got, exp;
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 3; k++) begin
        send(d, rnd128(), ok);
        wait_out(d, lat, got, to);
        exp = pop_exp();
        tests++;
        if (!ok || to || got !== exp) begin
          fails++;
          $display("FAIL random[%0d.%0d]: got %h want %h", d, k, got, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      abort[d]     = 1'b0;
      out_ready[d] = 1'b1;
      in_data[d]   = '0;
    end
    build_table();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_shift();
    test_noshift();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
